// File: rtl/dc_bsp_pkg.sv
// Board support constants shared by the ASP interrupt path: source bit positions,
// IRQ CSR word offsets and the responder identification value.
package dc_bsp_pkg;

  localparam int BSP_AVMM_NUM_IRQ_USED = 3;

  localparam int DMA_0_IRQ_BIT  = 0;
  localparam int KERNEL_IRQ_BIT = 1;
  localparam int DMA_1_IRQ_BIT  = 2;

  localparam logic [63:0] ASP_IRQ_CSR_ID = 64'h4153_505F_4952_5101;

  localparam int IRQ_CSR_ID      = 0;
  localparam int IRQ_CSR_PENDING = 1;
  localparam int IRQ_CSR_ENABLE  = 2;
  localparam int IRQ_CSR_RAW     = 3;
  localparam int IRQ_CSR_FORCE   = 4;
  localparam int IRQ_CSR_COUNT0  = 5;

  typedef logic [BSP_AVMM_NUM_IRQ_USED-1:0] irq_vec_t;

endpackage

// File: rtl/asp_irq_src_cell.sv
// One interrupt source: input register, edge/level event detect, sticky pending bit
// and a saturating event counter.
module asp_irq_src_cell
  import dc_bsp_pkg::*;
#(
  parameter bit EDGE      = 1'b1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 src,
  input  logic                 w1c,
  input  logic                 force_set,
  input  logic                 cnt_clr,
  output logic                 pending,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 src_q_r;
  logic                 pending_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic                 event_s;
  logic                 pending_next_s;
  logic [CNT_WIDTH-1:0] count_next_s;

  // Event detect: a new event sets pending even when software clears it in the same cycle.
  always_comb begin
    event_s = 1'b0;
    if (EDGE) begin
      event_s = src & ~src_q_r;
    end else begin
      event_s = src;
    end
    pending_next_s = event_s | force_set | (pending_r & ~w1c);
  end

  // Counter next state: clear has priority but an event in the clear cycle still counts.
  always_comb begin
    count_next_s = count_r;
    if (cnt_clr) begin
      if (event_s) begin
        count_next_s = CNT_ONE;
      end else begin
        count_next_s = CNT_ZERO;
      end
    end else if (event_s && (count_r != CNT_MAX)) begin
      count_next_s = count_r + CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q_r   <= 1'b0;
      pending_r <= 1'b0;
      count_r   <= CNT_ZERO;
    end else begin
      src_q_r   <= src;
      pending_r <= pending_next_s;
      count_r   <= count_next_s;
    end
  end

  assign pending = pending_r;
  assign count   = count_r;

endmodule

// File: rtl/asp_irq_csr_responder.sv
// ASP interrupt consumer: per-source pending/counter cells, enable mask, 64-bit AVMM
// CSR responder with fixed one-cycle read latency and a registered host interrupt.
module asp_irq_csr_responder
  import dc_bsp_pkg::*;
#(
  parameter int                 NUM_IRQ        = BSP_AVMM_NUM_IRQ_USED,
  parameter logic [NUM_IRQ-1:0] EDGE_MODE      = 3'b101,
  parameter int                 CSR_ADDR_WIDTH = 4,
  parameter int                 CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_IRQ-1:0]        irq_src,
  input  logic [CSR_ADDR_WIDTH-1:0] avmm_address,
  input  logic                      avmm_read,
  input  logic                      avmm_write,
  input  logic [63:0]               avmm_writedata,
  input  logic [7:0]                avmm_byteenable,
  output logic [63:0]               avmm_readdata,
  output logic                      avmm_readdatavalid,
  output logic                      avmm_waitrequest,
  output logic                      irq_out
);

  localparam logic [CSR_ADDR_WIDTH-1:0] A_ID    = CSR_ADDR_WIDTH'(IRQ_CSR_ID);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_PEND  = CSR_ADDR_WIDTH'(IRQ_CSR_PENDING);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_EN    = CSR_ADDR_WIDTH'(IRQ_CSR_ENABLE);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_RAW   = CSR_ADDR_WIDTH'(IRQ_CSR_RAW);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_FORCE = CSR_ADDR_WIDTH'(IRQ_CSR_FORCE);

  logic [NUM_IRQ-1:0]   pending_s;
  logic [CNT_WIDTH-1:0] count_s [NUM_IRQ];
  logic [NUM_IRQ-1:0]   enable_r;
  logic [NUM_IRQ-1:0]   w1c_s;
  logic [NUM_IRQ-1:0]   force_s;
  logic [NUM_IRQ-1:0]   cnt_clr_s;
  logic                 wr_en_s;
  logic [63:0]          rdata_s;
  logic [63:0]          readdata_r;
  logic                 readdatavalid_r;
  logic                 irq_out_r;

  // Write decode; only byte lane 0 carries the mask registers, counter clear ignores lanes.
  always_comb begin
    w1c_s     = {NUM_IRQ{1'b0}};
    force_s   = {NUM_IRQ{1'b0}};
    cnt_clr_s = {NUM_IRQ{1'b0}};
    wr_en_s   = 1'b0;
    if (avmm_write) begin
      if (avmm_byteenable[0]) begin
        case (avmm_address)
          A_PEND:  w1c_s   = avmm_writedata[NUM_IRQ-1:0];
          A_EN:    wr_en_s = 1'b1;
          A_FORCE: force_s = avmm_writedata[NUM_IRQ-1:0];
          default: wr_en_s = 1'b0;
        endcase
      end else begin
        wr_en_s = 1'b0;
      end
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (avmm_address == CSR_ADDR_WIDTH'(IRQ_CSR_COUNT0 + i)) begin
          cnt_clr_s[i] = 1'b1;
        end else begin
          cnt_clr_s[i] = 1'b0;
        end
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_IRQ; g++) begin : g_src
      asp_irq_src_cell #(
        .EDGE      (EDGE_MODE[g]),
        .CNT_WIDTH (CNT_WIDTH)
      ) u_cell (
        .clk       (clk),
        .reset_n   (reset_n),
        .src       (irq_src[g]),
        .w1c       (w1c_s[g]),
        .force_set (force_s[g]),
        .cnt_clr   (cnt_clr_s[g]),
        .pending   (pending_s[g]),
        .count     (count_s[g])
      );
    end
  endgenerate

  // Read mux over current register state, so a same-cycle write is not yet visible.
  always_comb begin
    rdata_s = 64'd0;
    case (avmm_address)
      A_ID:    rdata_s = ASP_IRQ_CSR_ID;
      A_PEND:  rdata_s = 64'(pending_s);
      A_EN:    rdata_s = 64'(enable_r);
      A_RAW:   rdata_s = 64'(irq_src);
      A_FORCE: rdata_s = 64'd0;
      default: begin
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (avmm_address == CSR_ADDR_WIDTH'(IRQ_CSR_COUNT0 + i)) begin
            rdata_s = 64'(count_s[i]);
          end else begin
            rdata_s = rdata_s;
          end
        end
      end
    endcase
  end

  // Enable mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_r <= {NUM_IRQ{1'b0}};
    end else if (wr_en_s) begin
      enable_r <= avmm_writedata[NUM_IRQ-1:0];
    end else begin
      enable_r <= enable_r;
    end
  end

  // Read response pipeline; readdata holds between responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r      <= 64'd0;
      readdatavalid_r <= 1'b0;
    end else begin
      readdatavalid_r <= avmm_read;
      if (avmm_read) begin
        readdata_r <= rdata_s;
      end else begin
        readdata_r <= readdata_r;
      end
    end
  end

  // Host interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_out_r <= 1'b0;
    end else begin
      irq_out_r <= |(pending_s & enable_r);
    end
  end

  assign avmm_readdata      = readdata_r;
  assign avmm_readdatavalid = readdatavalid_r;
  assign avmm_waitrequest   = 1'b0;
  assign irq_out            = irq_out_r;

endmodule

// File: tb/tb_asp_irq_csr_responder.sv
// Directed self-checking bench for asp_irq_csr_responder (CNT_WIDTH=4 to reach saturation).
module tb_asp_irq_csr_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  irq_src = 3'b000;
  logic [3:0]  avmm_address = 4'd0;
  logic        avmm_read = 1'b0;
  logic        avmm_write = 1'b0;
  logic [63:0] avmm_writedata = 64'd0;
  logic [7:0]  avmm_byteenable = 8'h00;
  logic [63:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic        avmm_waitrequest;
  logic        irq_out;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [3:0] A_ID = 4'd0, A_PEND = 4'd1, A_EN = 4'd2, A_RAW = 4'd3,
                         A_FORCE = 4'd4, A_CNT0 = 4'd5, A_CNT1 = 4'd6, A_CNT2 = 4'd7;

  asp_irq_csr_responder #(
    .NUM_IRQ        (3),
    .EDGE_MODE      (3'b101),
    .CSR_ADDR_WIDTH (4),
    .CNT_WIDTH      (4)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .irq_src            (irq_src),
    .avmm_address       (avmm_address),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .avmm_waitrequest   (avmm_waitrequest),
    .irq_out            (irq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [63:0] data, input logic [7:0] be);
    avmm_address    = addr;
    avmm_writedata  = data;
    avmm_byteenable = be;
    avmm_write      = 1'b1;
    tick();
    avmm_write      = 1'b0;
    avmm_byteenable = 8'h00;
  endtask

  task automatic rd(input logic [3:0] addr, input logic [63:0] exp, input string tag);
    avmm_address = addr;
    avmm_read    = 1'b1;
    tick();
    avmm_read    = 1'b0;
    check({tag, "_rdv"}, 64'(avmm_readdatavalid), 64'd1);
    check(tag, avmm_readdata, exp);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    tick();
    tick();
    check("reset_irq_out", 64'(irq_out), 64'd0);
    check("reset_rdv", 64'(avmm_readdatavalid), 64'd0);
    check("reset_readdata", avmm_readdata, 64'd0);
    check("waitrequest", 64'(avmm_waitrequest), 64'd0);
    reset_n = 1'b1;
    tick();
    rd(A_ID, 64'h4153_505F_4952_5101, "id");

    // single edge pulse on src0
    wr(A_EN, 64'd7, 8'hFF);
    rd(A_EN, 64'd7, "enable_7");
    irq_src = 3'b001;
    tick();
    irq_src = 3'b000;
    check("pulse_irq_after_1_edge", 64'(irq_out), 64'd0);
    rd(A_PEND, 64'd1, "pulse_pending");
    check("pulse_irq_after_2_edges", 64'(irq_out), 64'd1);
    rd(A_CNT0, 64'd1, "pulse_count0");
    wr(A_PEND, 64'd1, 8'hFF);
    tick();
    check("w1c0_irq_low", 64'(irq_out), 64'd0);

    // level source cannot be cleared while high
    irq_src = 3'b010;
    tick();
    wr(A_PEND, 64'd2, 8'hFF);
    rd(A_PEND, 64'd2, "level_w1c_held");
    irq_src = 3'b000;
    wr(A_PEND, 64'd2, 8'hFF);
    check("level_irq_one_edge", 64'(irq_out), 64'd1);
    tick();
    check("level_irq_two_edges", 64'(irq_out), 64'd0);

    // force with mask off, then enable
    wr(A_EN, 64'd0, 8'hFF);
    wr(A_FORCE, 64'd4, 8'hFF);
    tick();
    check("force_masked_irq", 64'(irq_out), 64'd0);
    rd(A_PEND, 64'd4, "force_pending");
    wr(A_EN, 64'd4, 8'hFF);
    check("enable_irq_same_edge", 64'(irq_out), 64'd0);
    tick();
    check("enable_irq_next_edge", 64'(irq_out), 64'd1);
    rd(A_CNT2, 64'd0, "force_not_counted");
    rd(A_FORCE, 64'd0, "force_reads_0");
    wr(A_EN, 64'd0, 8'hFE);
    rd(A_EN, 64'd4, "enable_be0_off");

    // read and write in the same cycle
    avmm_address = A_EN; avmm_writedata = 64'd7; avmm_byteenable = 8'hFF;
    avmm_read = 1'b1; avmm_write = 1'b1;
    tick();
    avmm_read = 1'b0; avmm_write = 1'b0;
    check("rw_same_cycle_old", avmm_readdata, 64'd4);
    rd(A_EN, 64'd7, "rw_same_cycle_new");
    wr(A_PEND, 64'd4, 8'hFF);

    // event collides with W1C
    wr(A_FORCE, 64'd1, 8'hFF);
    irq_src = 3'b001;
    wr(A_PEND, 64'd1, 8'hFF);
    irq_src = 3'b000;
    rd(A_PEND, 64'd1, "collide_pending");
    rd(A_CNT0, 64'd2, "collide_count0");

    // saturation: 2 + 15 events clamps at 0xF
    for (int i = 0; i < 15; i++) begin
      irq_src = 3'b001;
      tick();
      irq_src = 3'b000;
      tick();
    end
    rd(A_CNT0, 64'hF, "count0_saturated");
    wr(A_CNT0, 64'd0, 8'h00);
    rd(A_CNT0, 64'd0, "count0_cleared");
    irq_src = 3'b001;
    wr(A_CNT0, 64'd0, 8'hFF);
    irq_src = 3'b000;
    rd(A_CNT0, 64'd1, "count0_clear_and_event");

    // raw view and readdata hold
    irq_src = 3'b110;
    rd(A_RAW, 64'd6, "raw");
    irq_src = 3'b000;
    tick();
    check("rdv_one_cycle", 64'(avmm_readdatavalid), 64'd0);
    check("readdata_hold", avmm_readdata, 64'd6);
    rd(4'd15, 64'd0, "unmapped");

    // reset while a read is outstanding
    avmm_address = A_PEND;
    avmm_read    = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check("rst_irq_out", 64'(irq_out), 64'd0);
    check("rst_readdata", avmm_readdata, 64'd0);
    tick();
    check("rst_rdv", 64'(avmm_readdatavalid), 64'd0);
    avmm_read = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_rdv", 64'(avmm_readdatavalid), 64'd0);
    check("post_rst_irq_out", 64'(irq_out), 64'd0);
    rd(A_PEND, 64'd0, "post_rst_pending");
    rd(A_EN, 64'd0, "post_rst_enable");
    rd(A_CNT0, 64'd0, "post_rst_count0");
    rd(A_CNT1, 64'd0, "post_rst_count1");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
